// File: rtl/arb_pkg.sv
// arb_pkg: arbitration mode constants and source-index width helper
package arb_pkg;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority pick starting at ptr, via a doubled request vector
module rr_pick import arb_pkg::*; #(
   parameter int N = 4,
   localparam int SW = clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [SW-1:0] gnt_idx,
   output logic          any
);
   logic [2*N-1:0] dbl;
   always_comb begin
      for (int j = 0; j < 2*N; j++)
         dbl[j] = req[j % N] && (j >= int'(ptr)) && (j < int'(ptr) + N);
   end
   // descending scan so the lowest set position of the window wins
   always_comb begin
      gnt_onehot = '0;
      gnt_idx = '0;
      any = 1'b0;
      for (int j = 2*N-1; j >= 0; j--) begin
         if (dbl[j]) begin
            gnt_onehot = '0;
            gnt_onehot[j % N] = 1'b1;
            gnt_idx = SW'(j % N);
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/arb_muxn.sv
// arb_muxn: N-channel valid/ready arbiter onto one registered output channel
module arb_muxn import arb_pkg::*; #(
   parameter int N = 4,
   parameter int W = 64,
   parameter int MODE = ARB_RR,
   localparam int SW = clog2_min1(N)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_src,
   input  logic           out_ready
);
   logic [SW-1:0] ptr, pick_ptr, gnt_idx;
   logic [N-1:0]  gnt;
   logic          any, can_load, load;
   logic [W-1:0]  mux;
   assign pick_ptr = (MODE == ARB_RR) ? ptr : '0;
   rr_pick #(.N(N)) u_pick (
      .req(in_valid), .ptr(pick_ptr), .gnt_onehot(gnt), .gnt_idx(gnt_idx), .any(any)
   );
   assign can_load = !out_valid || out_ready;
   assign load     = reset_n && any && can_load;
   assign in_ready = load ? gnt : '0;
   always_comb begin
      mux = '0;
      for (int k = 0; k < N; k++)
         mux = mux | (in_data[k*W +: W] & {W{gnt[k]}});
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= '0;
      end else begin
         if (load) begin
            out_data <= mux;
            out_src  <= gnt_idx;
            ptr      <= (MODE != ARB_RR || gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;
         end
         out_valid <= load || (out_valid && !out_ready);
      end
   end
endmodule
